sync_fifo_lvl: RTL and testbench
================================

# sync_fifo_lvl

Parametrised synchronous FIFO: the next-generation buffer for the SoC's UART, SPI, and DMA paths. Adds:
- arbitrary (non-power-of-two) depth
- occupancy level output
- programmable almost-full / almost-empty thresholds
- selectable show-ahead or registered read port
- optional sticky overflow/underflow error flags

A single clock domain is used throughout. Rejected operations never corrupt state.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 4, number of entries (≥2, any integer)
- AF_THRESH, DEPTH-1, almost_full asserts when level ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserts when level ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 1, 1 = show-ahead read port, 0 = registered read port
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- din  in  DATA_WIDTH  write data
- push  in  1  write request
- pop  in  1  read request
- dout  out  DATA_WIDTH  read data
- dout_valid  out  1  dout holds valid data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AF_THRESH
- almost_empty  out  1  level ≤ AE_THRESH
- level  out  $clog2(DEPTH+1)  current occupancy 0..DEPTH
- overflow  out  1  sticky: push rejected (only with SYNC_FIFO_LVL_ERR_EN)
- underflow  out  1  sticky: pop rejected (only with SYNC_FIFO_LVL_ERR_EN)
- err_clr  in  1  clears overflow/underflow (only with SYNC_FIFO_LVL_ERR_EN)

## Operation
- State: rd_ptr and wr_ptr, each $clog2(DEPTH) bits; level register; storage array DEPTH × DATA_WIDTH.
- Pointers increment modulo DEPTH: the value DEPTH-1 wraps to 0 explicitly. No reliance on power-of-two overflow.
- Acceptance rules:
  - push_ok = push & (!full | pop)
  - pop_ok = pop & !empty
- Accepted push writes din to mem[wr_ptr] and advances wr_ptr. Accepted pop advances rd_ptr.
- level_next = level + push_ok - pop_ok.
- Simultaneous push+pop:
  - when full: both accepted, level stays DEPTH, write lands in the slot being vacated.
  - when empty: push accepted, pop rejected, level becomes 1.
  - otherwise: both accepted, level unchanged.
- Rejected push or pop changes no pointer, level or storage.
- full, empty, almost_full and almost_empty decode combinationally from the level register only, never from push/pop.
- FWFT=1: dout = mem[rd_ptr] (combinational); dout_valid = !empty.
- FWFT=0:
  - on pop_ok, dout register loads mem[rd_ptr] and dout_valid goes to 1 next cycle.
  - a pop with no acceptance clears dout_valid.
  - dout holds its last value when pop is low.

## Timing
- Write to read visibility (FWFT=1): a word pushed in cycle N is on dout with dout_valid=1 in cycle N+1 if the FIFO was empty.
- FWFT=0: data popped in cycle N appears on dout in cycle N+1.
- level and all flags update one cycle after the accepting edge.
- Reset values:
  - rd_ptr = wr_ptr = 0, level = 0
  - empty = 1, full = 0, almost_full = 0
  - almost_empty = 1
  - dout_valid = 0
  - dout = 0 when FWFT=0; don't-care when FWFT=1
  - overflow = underflow = 0
- Storage is not reset.
- Reset asserted mid-stream discards all contents in one cycle. push and pop are ignored while reset is high.

## Configuration
- SYNC_FIFO_LVL_ERR_EN defined:
  - overflow sets on push & !push_ok; underflow sets on pop & !pop_ok.
  - both hold until err_clr or reset.
  - err_clr has priority over a same-cycle set.
- Not defined: the overflow, underflow and err_clr ports are absent. Rejected operations are silently dropped as above.

## Test plan
- Reset, then DEPTH=5 (non-power-of-two): push 0x11..0x15 → full=1, level=5. Pop 5 → 0x11..0x15 in order, empty=1, level=0. Repeat twice to exercise wrap.
- Full + push&pop same cycle with din=0xAA → level stays 5. The subsequent 5 pops return old words 2..5 then 0xAA.
- Empty + push&pop same cycle with din=0x3C → level=1. With ERR_EN, underflow=1. Next pop returns 0x3C.
- AF_THRESH=4, AE_THRESH=1: fill 0→5 → almost_empty falls at level 2, almost_full rises at level 4. Both changes occur exactly one cycle after the accepting edge.
- FWFT=0: push 0x5A, then pop in cycle N → dout=0x5A and dout_valid=1 in N+1. Idle cycle → dout_valid=0, dout holds 0x5A.
- ERR_EN, push on full → overflow=1, contents unchanged. err_clr with simultaneous rejected push → overflow=0. Mid-stream reset at level 3 → level=0, empty=1 next cycle.

Source files
------------

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO of any depth (two or more entries) with an occupancy level,
// programmable almost-full/almost-empty thresholds and a show-ahead or registered read port.
// Define SYNC_FIFO_LVL_ERR_EN to add the sticky overflow/underflow flags and the err_clr input.
// Rejected pushes and pops leave pointers, level and storage untouched.
module sync_fifo_lvl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned AF_THRESH  = DEPTH - 1,
   parameter int unsigned AE_THRESH  = 1,
   parameter int unsigned FWFT       = 1,
   localparam int unsigned PTR_W     = $clog2(DEPTH),
   localparam int unsigned LVL_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
`ifdef SYNC_FIFO_LVL_ERR_EN
   input  logic                  err_clr,
   output logic                  overflow,
   output logic                  underflow,
`endif
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  push,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [LVL_W-1:0]      level
);

   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AF_LVL    = LVL_W'(AF_THRESH);
   localparam logic [LVL_W-1:0] AE_LVL    = LVL_W'(AE_THRESH);
   localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  push_ok, pop_ok;

   // Status flags decode from the level register only, so they lag the accepting edge by one cycle.
   always_comb begin
      full         = (level_q == DEPTH_LVL);
      empty        = (level_q == '0);
      almost_full  = (level_q >= AF_LVL);
      almost_empty = (level_q <= AE_LVL);
      level        = level_q;
   end

   // Acceptance: a push on full is taken only when a pop frees the slot in the same cycle.
   always_comb begin
      push_ok = push & (~full | pop);
      pop_ok  = pop & ~empty;
   end

   // Next pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers; reset discards all contents in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is deliberately not reset; writes are blocked while reset is high.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   if (FWFT != 0) begin : g_show_ahead
      // Head of queue is presented combinationally.
      always_comb begin
         dout       = mem_q[rd_ptr_q];
         dout_valid = ~empty;
      end
   end else begin : g_registered
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  dout_valid_q, dout_valid_d;

      // Load the head on an accepted pop; valid only in the cycle following an accepted pop.
      always_comb begin
         dout_d       = pop_ok ? mem_q[rd_ptr_q] : dout_q;
         dout_valid_d = pop_ok;
      end

      // Registered read port.
      always_ff @(posedge clk) begin
         if (reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
         end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
         end
      end

      // Drive the port from the read registers.
      always_comb begin
         dout       = dout_q;
         dout_valid = dout_valid_q;
      end
   end

`ifdef SYNC_FIFO_LVL_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error flags; err_clr wins over a set in the same cycle.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push && !push_ok) overflow_d = 1'b1;
         if (pop && !pop_ok)   underflow_d = 1'b1;
      end
   end

   // Error flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Drive the error ports.
   always_comb begin
      overflow  = overflow_q;
      underflow = underflow_q;
   end
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: DEPTH=5, AF_THRESH=4, AE_THRESH=1. Two instances share the
// same stimulus, one show-ahead (FWFT=1) and one with a registered read port (FWFT=0).
module tb_sync_fifo_lvl;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 5;
   localparam int unsigned LW    = $clog2(DEPTH + 1);

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          push  = 1'b0;
   logic          pop   = 1'b0;
   logic [DW-1:0] din   = '0;

   logic [DW-1:0] a_dout, b_dout;
   logic          a_dv, b_dv, a_full, b_full, a_empty, b_empty;
   logic          a_af, b_af, a_ae, b_ae;
   logic [LW-1:0] a_level, b_level;
`ifdef SYNC_FIFO_LVL_ERR_EN
   logic          err_clr = 1'b0;
   logic          a_ovf, a_unf, b_ovf, b_unf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sync_fifo_lvl #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)
   ) u_fwft (
      .clk(clk), .reset(reset),
`ifdef SYNC_FIFO_LVL_ERR_EN
      .err_clr(err_clr), .overflow(a_ovf), .underflow(a_unf),
`endif
      .din(din), .push(push), .pop(pop), .dout(a_dout), .dout_valid(a_dv),
      .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .level(a_level)
   );

   sync_fifo_lvl #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)
   ) u_reg (
      .clk(clk), .reset(reset),
`ifdef SYNC_FIFO_LVL_ERR_EN
      .err_clr(err_clr), .overflow(b_ovf), .underflow(b_unf),
`endif
      .din(din), .push(push), .pop(pop), .dout(b_dout), .dout_valid(b_dv),
      .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .level(b_level)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      tick();
      tick();
      chk("rst_level", 32'(a_level), 0);
      chk("rst_empty", 32'(a_empty), 1);
      chk("rst_full", 32'(a_full), 0);
      chk("rst_af", 32'(a_af), 0);
      chk("rst_ae", 32'(a_ae), 1);
      chk("rst_dv_fwft", 32'(a_dv), 0);
      chk("rst_dv_reg", 32'(b_dv), 0);
      chk("rst_dout_reg", 32'(b_dout), 0);
      chk("rst_level_reg", 32'(b_level), 0);
`ifdef SYNC_FIFO_LVL_ERR_EN
      chk("rst_ovf", 32'(a_ovf), 0);
      chk("rst_unf", 32'(a_unf), 0);
`endif
      reset = 1'b0;

      // Three fill/drain rounds of 0x11..0x15 to exercise pointer wrap at DEPTH=5
      for (int r = 0; r < 3; r++) begin
         push = 1'b1;
         for (int k = 1; k <= 5; k++) begin
            din = 8'(8'h10 + k);
            tick();
            chk("fill_level", 32'(a_level), 32'(k));
            chk("fill_ae", 32'(a_ae), (k <= 1) ? 1 : 0);
            chk("fill_af", 32'(a_af), (k >= 4) ? 1 : 0);
            chk("fill_dout_fwft", 32'(a_dout), 32'h11);
            chk("fill_dv_fwft", 32'(a_dv), 1);
         end
         push = 1'b0;
         chk("fill_full", 32'(a_full), 1);
         chk("fill_empty", 32'(a_empty), 0);
         pop = 1'b1;
         for (int j = 0; j < 5; j++) begin
            chk("drain_dout_fwft", 32'(a_dout), 32'(8'h11 + j));
            tick();
            chk("drain_dout_reg", 32'(b_dout), 32'(8'h11 + j));
            chk("drain_dv_reg", 32'(b_dv), 1);
            chk("drain_level", 32'(a_level), 32'(4 - j));
         end
         pop = 1'b0;
         chk("drain_empty", 32'(a_empty), 1);
         chk("drain_dv_fwft", 32'(a_dv), 0);
      end

      // Registered read port: pop in N, data in N+1, idle clears valid and holds data
      din  = 8'h5A;
      push = 1'b1;
      tick();
      push = 1'b0;
      chk("5a_dout_fwft", 32'(a_dout), 32'h5A);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("5a_dout_reg", 32'(b_dout), 32'h5A);
      chk("5a_dv_reg", 32'(b_dv), 1);
      tick();
      chk("5a_idle_dv_reg", 32'(b_dv), 0);
      chk("5a_idle_dout_reg", 32'(b_dout), 32'h5A);

      // Full plus simultaneous push and pop: write lands in the vacated slot
      push = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         din = 8'(8'h20 + k);
         tick();
      end
      chk("fullpp_pre_full", 32'(a_full), 1);
      din = 8'hAA;
      pop = 1'b1;
      chk("fullpp_head", 32'(a_dout), 32'h21);
      tick();
      push = 1'b0;
      chk("fullpp_level", 32'(a_level), 5);
      chk("fullpp_full", 32'(a_full), 1);
      chk("fullpp_dout_reg", 32'(b_dout), 32'h21);
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("fullpp_drain_reg", 32'(b_dout), (j == 4) ? 32'hAA : 32'(8'h22 + j));
      end
      pop = 1'b0;
      chk("fullpp_empty", 32'(a_empty), 1);

      // Empty plus simultaneous push and pop: only the push is taken
      din  = 8'h3C;
      push = 1'b1;
      pop  = 1'b1;
      tick();
      push = 1'b0;
      pop  = 1'b0;
      chk("emptypp_level", 32'(a_level), 1);
      chk("emptypp_dv_reg", 32'(b_dv), 0);
      chk("emptypp_dout_fwft", 32'(a_dout), 32'h3C);
`ifdef SYNC_FIFO_LVL_ERR_EN
      chk("emptypp_unf", 32'(a_unf), 1);
      chk("emptypp_ovf", 32'(a_ovf), 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("unf_clr", 32'(a_unf), 0);
`endif
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("emptypp_pop_reg", 32'(b_dout), 32'h3C);
      chk("emptypp_pop_level", 32'(a_level), 0);

      // Lone pop on empty is dropped
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("underrun_level", 32'(a_level), 0);
      chk("underrun_dv_reg", 32'(b_dv), 0);
      chk("underrun_dout_reg", 32'(b_dout), 32'h3C);

      // Push on full is rejected without corrupting contents
      push = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         din = 8'(8'h40 + k);
         tick();
      end
      din = 8'h99;
      tick();
      push = 1'b0;
      chk("ovf_level", 32'(a_level), 5);
      chk("ovf_head", 32'(a_dout), 32'h41);
`ifdef SYNC_FIFO_LVL_ERR_EN
      chk("ovf_flag", 32'(a_ovf), 1);
      err_clr = 1'b1;
      push    = 1'b1;
      tick();
      err_clr = 1'b0;
      push    = 1'b0;
      chk("ovf_clr_priority", 32'(a_ovf), 0);
      chk("ovf_clr_level", 32'(a_level), 5);
`endif
      pop = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("ovf_drain_reg", 32'(b_dout), 32'(8'h41 + j));
      end
      pop = 1'b0;
      chk("ovf_drain_empty", 32'(a_empty), 1);

      // Mid-stream reset at level 3, with a push held during reset
      push = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         din = 8'(8'h60 + k);
         tick();
      end
      chk("mid_level3", 32'(a_level), 3);
      pop   = 1'b1;
      reset = 1'b1;
      tick();
      chk("mid_rst_level", 32'(a_level), 0);
      chk("mid_rst_empty", 32'(a_empty), 1);
      chk("mid_rst_dv_reg", 32'(b_dv), 0);
      chk("mid_rst_dout_reg", 32'(b_dout), 0);
      reset = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      tick();
      chk("post_rst_level", 32'(a_level), 0);
      chk("post_rst_ae", 32'(a_ae), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
